mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter: STATE_W, 4, width of the state register and the state debug output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  7  instruction[6:0] from the instruction register; valid from the DECODE state onward.
REQ-005 SHALL have port: mem_ready  input  1  memory completed the current request this cycle.
REQ-006 SHALL have port: br_taken  input  1  branch comparator result for the current instruction.
REQ-007 SHALL have port: mem_req  output  1  memory request; held high until mem_ready is sampled high.
REQ-008 SHALL have port: mem_we  output  1  memory write qualifier for mem_req.
REQ-009 SHALL have ports: ir_write, pc_write, reg_write  output  1 each  register write enables.
REQ-010 SHALL have port: pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut register.
REQ-011 SHALL have port: imm_sel  output  3  immediate format: 000 = I, 001 = S, 010 = SB, 011 = U, 100 = UJ.
REQ-012 SHALL have port: alu_src_a  output  2  ALU A operand: 00 = PC, 01 = rs1, 10 = zero, 11 = old_pc (the PC latched on ir_write).
REQ-013 SHALL have port: alu_src_b  output  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-014 SHALL have port: alu_op  output  2  ALU operation: 00 = add, 01 = compare, 10 = funct-decoded.
REQ-015 SHALL have port: wb_sel  output  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC (link address).
REQ-016 SHALL have ports: trap  output  1  sticky illegal-opcode flag; state  output  STATE_W  current state.

Function
REQ-017 SHALL implement a state register with the following encoding: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC = 6, ALU_WB = 7, BRANCH = 8, JUMP = 9, UPPER = 10, TRAP = 11.
REQ-018 SHALL drive every output to 0 in any cycle that is not named for it in REQ-019..REQ-029; outputs decode from state and the current-cycle inputs.
REQ-019 FETCH SHALL assert mem_req.
  - When mem_ready = 1: in the same cycle assert ir_write and pc_write, with pc_src = 00, alu_src_a = 00, alu_src_b = 01, alu_op = 00; go to DECODE.
  - Otherwise: stay in FETCH.
REQ-020 DECODE SHALL drive alu_src_a = 11, alu_src_b = 10, alu_op = 00, with imm_sel = 100 for JAL and 010 otherwise, so that ALUOut holds the jump or branch target.
REQ-021 DECODE SHALL select the next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 or 0010011 -> EXEC
  - 1100011 -> BRANCH
  - 1101111 or 1100111 -> JUMP
  - 0110111 or 0010111 -> UPPER
  - any other value -> TRAP
REQ-022 MEM_ADDR SHALL drive alu_src_a = 01, alu_src_b = 10, alu_op = 00, imm_sel = 000 for loads and 001 for stores; next state MEM_RD for a load, MEM_WR for a store.
REQ-023 MEM_RD SHALL assert mem_req with mem_we = 0; go to MEM_WB on mem_ready, else stay.
REQ-024 MEM_WR SHALL assert mem_req and mem_we; go to FETCH on mem_ready, else stay.
REQ-025 MEM_WB SHALL assert reg_write with wb_sel = 01; next state FETCH.
REQ-026 EXEC SHALL drive alu_src_a = 01, alu_op = 10, imm_sel = 000, and alu_src_b = 00 for OP or 10 for OP-IMM; next state ALU_WB.
REQ-027 ALU_WB SHALL assert reg_write with wb_sel = 00; next state FETCH.
REQ-028 BRANCH SHALL drive alu_src_a = 01, alu_src_b = 00, alu_op = 01; pc_write = br_taken with pc_src = 01; next state FETCH.
REQ-029 JUMP SHALL assert reg_write with wb_sel = 10 and assert pc_write; next state FETCH.
  - JAL: pc_src = 01.
  - JALR: pc_src = 00, alu_src_a = 01, alu_src_b = 10, imm_sel = 000, alu_op = 00.
REQ-030 UPPER SHALL drive imm_sel = 011, alu_src_b = 10, alu_op = 00, reg_write = 1, wb_sel = 00, with alu_src_a = 10 for LUI and 11 for AUIPC; next state FETCH.
REQ-031 TRAP SHALL hold trap = 1 and remain in TRAP until rst; no memory or register write is issued while in TRAP.
REQ-032 SHALL have the following minimum latencies with zero memory wait:
  - Load: 5 cycles
  - Store and ALU: 4 cycles
  - Branch, jump and upper: 3 cycles
  - Each cycle with mem_ready low SHALL add exactly one cycle.

Reset
REQ-033 rst = 1 at a rising edge SHALL set state to FETCH and clear trap, including when rst arrives mid-wait in MEM_RD or MEM_WR or while in TRAP.
REQ-034 While rst = 1, all outputs SHALL be 0 (mem_req = 0); mem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-035 Bench SHALL cover: ADD (0110011) with mem_ready always 1 -> state sequence 0, 1, 6, 7, 0; reg_write = 1 only in ALU_WB, with wb_sel = 00.
REQ-036 Bench SHALL cover: LW (0000011) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_req held high for 3 MEM_RD cycles; MEM_WB has reg_write = 1 and wb_sel = 01.
REQ-037 Bench SHALL cover: BEQ (1100011) with br_taken = 1, then again with br_taken = 0 -> pc_write = 1 with pc_src = 01 in BRANCH for the first, pc_write = 0 for the second; both return to FETCH.
REQ-038 Bench SHALL cover: JAL (1101111) -> imm_sel = 100 in DECODE; JUMP has reg_write = 1, wb_sel = 10, pc_write = 1, pc_src = 01.
REQ-039 Bench SHALL cover: opcode 1111111 -> TRAP with trap = 1 held for 10 cycles and mem_req = 0; rst for 1 cycle -> state 0, trap 0.
REQ-040 Bench SHALL cover: rst asserted during a MEM_WR wait -> mem_req = 0 during rst; FETCH on the next cycle with no write completed.

Source files
------------

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Main control state machine for a multi-cycle RV32I-style datapath. It walks
// each instruction through fetch, decode and a class-specific execute
// sequence, and steers the datapath muxes and write enables every cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   opcode     in   instruction[6:0]; meaningful from DECODE onward
//   mem_ready  in   memory finished the current request this cycle
//   br_taken   in   branch comparator result
//   mem_req    out  memory request, held until mem_ready is seen
//   mem_we     out  write qualifier for mem_req
//   ir_write   out  instruction register write enable
//   pc_write   out  PC write enable
//   reg_write  out  register file write enable
//   pc_src     out  00 ALU result, 01 ALUOut register
//   imm_sel    out  000 I, 001 S, 010 SB, 011 U, 100 UJ
//   alu_src_a  out  00 PC, 01 rs1, 10 zero, 11 old_pc
//   alu_src_b  out  00 rs2, 01 constant 4, 10 immediate
//   alu_op     out  00 add, 01 compare, 10 funct-decoded
//   wb_sel     out  00 ALU, 01 memory data, 10 PC (link)
//   trap       out  sticky illegal-opcode flag
//   state      out  current state (debug)
// ---------------------------------------------------------------------------
module mc_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   input  logic               br_taken,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic [1:0]         pc_src,
   output logic [2:0]         imm_sel,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         wb_sel,
   output logic               trap,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEM_ADDR = STATE_W'(2),
      S_MEM_RD   = STATE_W'(3),
      S_MEM_WB   = STATE_W'(4),
      S_MEM_WR   = STATE_W'(5),
      S_EXEC     = STATE_W'(6),
      S_ALU_WB   = STATE_W'(7),
      S_BRANCH   = STATE_W'(8),
      S_JUMP     = STATE_W'(9),
      S_UPPER    = STATE_W'(10),
      S_TRAP     = STATE_W'(11)
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t     state_q, state_d;
   logic       trap_q;

   logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
   logic [1:0] pc_src_c, alu_src_a_c, alu_src_b_c, alu_op_c, wb_sel_c;
   logic [2:0] imm_sel_c;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP) trap_q <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves a signal unassigned and a latch is never inferred.
      state_d     = state_q;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      pc_src_c    = 2'b00;
      imm_sel_c   = 3'b000;
      alu_src_a_c = 2'b00;
      alu_src_b_c = 2'b00;
      alu_op_c    = 2'b00;
      wb_sel_c    = 2'b00;

      unique case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               // PC <= PC + 4 in the same cycle the instruction is latched.
               ir_write_c  = 1'b1;
               pc_write_c  = 1'b1;
               alu_src_b_c = 2'b01;
               state_d     = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute old_pc + imm so ALUOut holds the target.
            alu_src_a_c = 2'b11;
            alu_src_b_c = 2'b10;
            imm_sel_c   = (opcode == OP_JAL) ? 3'b100 : 3'b010;
            unique case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_OP, OP_IMM:     state_d = S_EXEC;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL, OP_JALR:   state_d = S_JUMP;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            imm_sel_c   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            state_d     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req_c = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b01;
            state_d     = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 2'b10;
            alu_src_b_c = (opcode == OP_IMM) ? 2'b10 : 2'b00;
            state_d     = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 2'b01;
            pc_write_c  = br_taken;
            pc_src_c    = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b10;
            pc_write_c  = 1'b1;
            if (opcode == OP_JAL) begin
               pc_src_c = 2'b01;
            end else begin
               // JALR target is rs1 + imm, taken straight from the ALU.
               alu_src_a_c = 2'b01;
               alu_src_b_c = 2'b10;
            end
            state_d = S_FETCH;
         end
         S_UPPER: begin
            imm_sel_c   = 3'b011;
            alu_src_b_c = 2'b10;
            reg_write_c = 1'b1;
            alu_src_a_c = (opcode == OP_LUI) ? 2'b10 : 2'b11;
            state_d     = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs are forced low for the whole reset cycle, before the state
   // register has actually been cleared.
   assign mem_req   = mem_req_c   & ~rst;
   assign mem_we    = mem_we_c    & ~rst;
   assign ir_write  = ir_write_c  & ~rst;
   assign pc_write  = pc_write_c  & ~rst;
   assign reg_write = reg_write_c & ~rst;
   assign pc_src    = rst ? 2'b00 : pc_src_c;
   assign imm_sel   = rst ? 3'b000 : imm_sel_c;
   assign alu_src_a = rst ? 2'b00 : alu_src_a_c;
   assign alu_src_b = rst ? 2'b00 : alu_src_b_c;
   assign alu_op    = rst ? 2'b00 : alu_op_c;
   assign wb_sel    = rst ? 2'b00 : wb_sel_c;
   assign trap      = trap_q & ~rst;
   assign state     = rst ? '0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed bench for mc_control_fsm. Each stimulus cycle pushes the expected
// output vector for that cycle into a queue; a monitor on the falling edge
// pops and compares against what the DUT presents.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] pc_src;
      logic [2:0] imm_sel;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic       trap;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       br_taken;
   logic       mem_req, mem_we, ir_write, pc_write, reg_write, trap;
   logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
   logic [2:0] imm_sel;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   obs_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
      .trap(trap), .state(state)
   );

   // Hand-written expected vectors, one per state/situation.
   function automatic obs_t e_zero();
      obs_t e = '0;
      return e;
   endfunction
   function automatic obs_t e_fetch(input logic rdy);
      obs_t e = '0;
      e.state = 4'd0; e.mem_req = 1'b1;
      if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b01; end
      return e;
   endfunction
   function automatic obs_t e_decode(input logic jal);
      obs_t e = '0;
      e.state = 4'd1; e.alu_src_a = 2'b11; e.alu_src_b = 2'b10;
      e.imm_sel = jal ? 3'b100 : 3'b010;
      return e;
   endfunction
   function automatic obs_t e_mem_addr(input logic store);
      obs_t e = '0;
      e.state = 4'd2; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
      e.imm_sel = store ? 3'b001 : 3'b000;
      return e;
   endfunction
   function automatic obs_t e_mem_rd();
      obs_t e = '0;
      e.state = 4'd3; e.mem_req = 1'b1;
      return e;
   endfunction
   function automatic obs_t e_mem_wb();
      obs_t e = '0;
      e.state = 4'd4; e.reg_write = 1'b1; e.wb_sel = 2'b01;
      return e;
   endfunction
   function automatic obs_t e_mem_wr();
      obs_t e = '0;
      e.state = 4'd5; e.mem_req = 1'b1; e.mem_we = 1'b1;
      return e;
   endfunction
   function automatic obs_t e_exec();
      obs_t e = '0;
      e.state = 4'd6; e.alu_src_a = 2'b01; e.alu_op = 2'b10; e.alu_src_b = 2'b00;
      return e;
   endfunction
   function automatic obs_t e_alu_wb();
      obs_t e = '0;
      e.state = 4'd7; e.reg_write = 1'b1; e.wb_sel = 2'b00;
      return e;
   endfunction
   function automatic obs_t e_branch(input logic tk);
      obs_t e = '0;
      e.state = 4'd8; e.alu_src_a = 2'b01; e.alu_op = 2'b01;
      e.pc_write = tk; e.pc_src = 2'b01;
      return e;
   endfunction
   function automatic obs_t e_jal();
      obs_t e = '0;
      e.state = 4'd9; e.reg_write = 1'b1; e.wb_sel = 2'b10;
      e.pc_write = 1'b1; e.pc_src = 2'b01;
      return e;
   endfunction
   function automatic obs_t e_trap();
      obs_t e = '0;
      e.state = 4'd11; e.trap = 1'b1;
      return e;
   endfunction

   // One stimulus cycle: drive inputs, queue the expected response, advance.
   task automatic cyc(input string nm, input logic [6:0] op, input logic rdy,
                      input logic tk, input logic r, input obs_t e);
      opcode    = op;
      mem_ready = rdy;
      br_taken  = tk;
      rst       = r;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input obs_t act, input obs_t e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                  nm, act, e, act.state, e.state);
      end
   endtask

   // Monitor: the DUT presents a full output vector every cycle.
   initial begin
      obs_t  act;
      obs_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {state, mem_req, mem_we, ir_write, pc_write, reg_write, pc_src,
                   imm_sel, alu_src_a, alu_src_b, alu_op, wb_sel, trap};
            check(nm, act, e);
         end
      end
   end

   localparam logic [6:0] ADD = 7'b0110011;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   initial begin
      int wait_cnt;
      rst = 1'b1; opcode = '0; mem_ready = 1'b0; br_taken = 1'b0;
      @(posedge clk);
      #1;
      cyc("reset_outputs", ADD, 1'b1, 1'b0, 1'b1, e_zero());

      // ADD, no wait: 0,1,6,7 then back to 0
      cyc("add_fetch",  ADD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("add_decode", ADD, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
      cyc("add_exec",   ADD, 1'b1, 1'b0, 1'b0, e_exec());
      cyc("add_alu_wb", ADD, 1'b1, 1'b0, 1'b0, e_alu_wb());

      // LW with two wait cycles in MEM_RD: 7 cycles total
      cyc("lw_fetch",    LW, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("lw_decode",   LW, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
      cyc("lw_mem_addr", LW, 1'b1, 1'b0, 1'b0, e_mem_addr(1'b0));
      cyc("lw_mem_rd_w1", LW, 1'b0, 1'b0, 1'b0, e_mem_rd());
      cyc("lw_mem_rd_w2", LW, 1'b0, 1'b0, 1'b0, e_mem_rd());
      cyc("lw_mem_rd_ok", LW, 1'b1, 1'b0, 1'b0, e_mem_rd());
      cyc("lw_mem_wb",   LW, 1'b1, 1'b0, 1'b0, e_mem_wb());

      // BEQ taken then not taken
      cyc("beq1_fetch",  BEQ, 1'b1, 1'b1, 1'b0, e_fetch(1'b1));
      cyc("beq1_decode", BEQ, 1'b1, 1'b1, 1'b0, e_decode(1'b0));
      cyc("beq1_taken",  BEQ, 1'b1, 1'b1, 1'b0, e_branch(1'b1));
      cyc("beq0_fetch",  BEQ, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("beq0_decode", BEQ, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
      cyc("beq0_not",    BEQ, 1'b1, 1'b0, 1'b0, e_branch(1'b0));

      // JAL
      cyc("jal_fetch",  JAL, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("jal_decode", JAL, 1'b1, 1'b0, 1'b0, e_decode(1'b1));
      cyc("jal_jump",   JAL, 1'b1, 1'b0, 1'b0, e_jal());

      // SW with reset landing during the MEM_WR wait
      cyc("sw_fetch",    SW, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("sw_decode",   SW, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
      cyc("sw_mem_addr", SW, 1'b1, 1'b0, 1'b0, e_mem_addr(1'b1));
      cyc("sw_mem_wr_w1", SW, 1'b0, 1'b0, 1'b0, e_mem_wr());
      cyc("sw_mem_wr_w2", SW, 1'b0, 1'b0, 1'b0, e_mem_wr());
      cyc("sw_rst_mid_wait", SW, 1'b0, 1'b0, 1'b1, e_zero());
      cyc("sw_after_rst_fetch", SW, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

      // Illegal opcode: TRAP is absorbing until reset
      cyc("bad_fetch",  BAD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
      cyc("bad_decode", BAD, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
      for (int i = 0; i < 10; i++)
         cyc($sformatf("trap_hold_%0d", i), BAD, 1'b1, 1'b0, 1'b0, e_trap());
      cyc("trap_rst",         BAD, 1'b1, 1'b0, 1'b1, e_zero());
      cyc("trap_after_rst",   ADD, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
      cyc("fetch_still_wait", ADD, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

      // Let the monitor drain; bounded so a stuck queue cannot hang the run.
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
